tb_icmp_rx_parser: RTL and testbench

- Receive-side byte-stream parser that sits directly upstream of the ICMP checksum calculator in the ethernet receiver test library.
- Walks each incoming Ethernet frame through the Ethernet, IPv4 and ICMP headers and qualifies ICMP echo requests addressed to the local IP.
- For each qualified request it emits a one-cycle start pulse and the initial checksum word, then a gap-free, pair-aligned payload byte stream that the calculator sums directly.

---
 rtl/tb_icmp_rx_parser.sv | 186 ++++++++++++++++++
 tb/tb_tb_icmp_rx_parser.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_icmp_rx_parser.sv
// ICMP echo-request receive parser: walks Ethernet/IPv4/ICMP headers, qualifies
// echo requests to LOCAL_IP and streams a pair-aligned payload to a checksum unit.
module tb_icmp_rx_parser #(
    parameter logic [31:0] LOCAL_IP   = 32'hC0A8_0001,
    parameter logic [7:0]  REPLY_TYPE = 8'h00
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_rx_valid,
    input  logic        i_rx_sof,
    input  logic        i_rx_eof,
    input  logic [7:0]  i_rx_data,
    output logic        o_icmp_valid,
    output logic        o_msg_valid,
    output logic [7:0]  o_byte,
    output logic [20:0] o_initial_sum,
    output logic        o_drop,
    output logic        o_abort
);

    typedef enum logic [2:0] {
        StIdle, StEth, StIp, StIcmp, StPayload, StPad, StSkip
    } state_e;

    state_e      r_state;
    logic [5:0]  r_idx;        // index of the next header byte
    logic [15:0] r_total_len;
    logic [7:0]  r_code;
    logic [15:0] r_rem;        // payload bytes still expected
    logic        r_odd;        // payload length is odd, pad needed
    logic        r_eof_seen;   // last payload byte carried eof
    logic        r_trunc;      // eof arrived before the last payload byte
    logic        r_icmp_valid;
    logic        r_msg_valid;
    logic [7:0]  r_byte;
    logic [20:0] r_initial_sum;
    logic        r_drop;
    logic        r_abort;

    logic        w_hdr_fail;
    logic [15:0] w_len;

    assign w_len = r_total_len - 16'd28;

    // Per-byte header qualification for the byte currently on i_rx_data
    always_comb begin
        w_hdr_fail = 1'b0;
        case (r_idx)
            6'd12:   w_hdr_fail = (i_rx_data != 8'h08);
            6'd13:   w_hdr_fail = (i_rx_data != 8'h00);
            6'd14:   w_hdr_fail = (i_rx_data != 8'h45);
            6'd17:   w_hdr_fail = ({r_total_len[15:8], i_rx_data} < 16'd28);
            6'd23:   w_hdr_fail = (i_rx_data != 8'h01);
            6'd30:   w_hdr_fail = (i_rx_data != LOCAL_IP[31:24]);
            6'd31:   w_hdr_fail = (i_rx_data != LOCAL_IP[23:16]);
            6'd32:   w_hdr_fail = (i_rx_data != LOCAL_IP[15:8]);
            6'd33:   w_hdr_fail = (i_rx_data != LOCAL_IP[7:0]);
            6'd34:   w_hdr_fail = (i_rx_data != 8'h08);
            default: w_hdr_fail = 1'b0;
        endcase
    end

    // Parser FSM with registered outputs
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= StIdle;
            r_idx         <= '0;
            r_total_len   <= '0;
            r_code        <= '0;
            r_rem         <= '0;
            r_odd         <= 1'b0;
            r_eof_seen    <= 1'b0;
            r_trunc       <= 1'b0;
            r_icmp_valid  <= 1'b0;
            r_msg_valid   <= 1'b0;
            r_byte        <= '0;
            r_initial_sum <= '0;
            r_drop        <= 1'b0;
            r_abort       <= 1'b0;
        end else begin
            r_icmp_valid <= 1'b0;
            r_msg_valid  <= 1'b0;
            r_byte       <= '0;
            r_drop       <= 1'b0;
            r_abort      <= 1'b0;
            if (i_rx_valid && i_rx_sof) begin
                // A pending pad still completes its pair; a live payload is cut short
                r_abort     <= (r_state == StPayload);
                r_msg_valid <= (r_state == StPad);
                r_trunc     <= 1'b0;
                r_eof_seen  <= 1'b0;
                r_idx       <= 6'd1;
                if (i_rx_eof) begin
                    r_drop  <= 1'b1;
                    r_state <= StIdle;
                end else begin
                    r_state <= StEth;
                end
            end else begin
                case (r_state)
                    StIdle: begin
                        r_state <= StIdle;
                    end
                    StEth, StIp, StIcmp: begin
                        if (!i_rx_valid) begin
                            r_drop  <= 1'b1;
                            r_state <= StSkip;
                        end else begin
                            r_idx <= r_idx + 6'd1;
                            if (r_idx == 6'd16) r_total_len[15:8] <= i_rx_data;
                            if (r_idx == 6'd17) r_total_len[7:0] <= i_rx_data;
                            if (r_idx == 6'd35) r_code <= i_rx_data;
                            if (w_hdr_fail) begin
                                r_drop  <= 1'b1;
                                r_state <= i_rx_eof ? StIdle : StSkip;
                            end else if (r_idx == 6'd37) begin
                                r_icmp_valid  <= 1'b1;
                                r_msg_valid   <= 1'b1;
                                r_initial_sum <= {5'b0, REPLY_TYPE, r_code};
                                r_rem         <= w_len;
                                r_odd         <= w_len[0];
                                if (w_len == 16'd0) begin
                                    r_state <= i_rx_eof ? StIdle : StSkip;
                                end else begin
                                    r_state <= StPayload;
                                    r_trunc <= i_rx_eof;
                                end
                            end else if (i_rx_eof) begin
                                r_drop  <= 1'b1;
                                r_state <= StIdle;
                            end else if (r_idx == 6'd13) begin
                                r_state <= StIp;
                            end else if (r_idx == 6'd33) begin
                                r_state <= StIcmp;
                            end
                        end
                    end
                    StPayload: begin
                        if (r_trunc) begin
                            // Frame already ended; close the message one cycle later
                            r_abort <= 1'b1;
                            r_trunc <= 1'b0;
                            r_state <= StIdle;
                        end else if (!i_rx_valid) begin
                            r_abort <= 1'b1;
                            r_state <= StSkip;
                        end else begin
                            r_msg_valid <= 1'b1;
                            r_byte      <= i_rx_data;
                            r_rem       <= r_rem - 16'd1;
                            if (r_rem == 16'd1) begin
                                if (r_odd) begin
                                    r_eof_seen <= i_rx_eof;
                                    r_state    <= StPad;
                                end else begin
                                    r_state <= i_rx_eof ? StIdle : StSkip;
                                end
                            end else if (i_rx_eof) begin
                                r_trunc <= 1'b1;
                            end
                        end
                    end
                    StPad: begin
                        r_msg_valid <= 1'b1;
                        r_eof_seen  <= 1'b0;
                        r_state     <= (r_eof_seen || (i_rx_valid && i_rx_eof)) ? StIdle : StSkip;
                    end
                    StSkip: begin
                        if (i_rx_valid && i_rx_eof) r_state <= StIdle;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    assign o_icmp_valid  = r_icmp_valid;
    assign o_msg_valid   = r_msg_valid;
    assign o_byte        = r_byte;
    assign o_initial_sum = r_initial_sum;
    assign o_drop        = r_drop;
    assign o_abort       = r_abort;

endmodule

// File: tb/tb_tb_icmp_rx_parser.sv
// Directed bench for tb_icmp_rx_parser: frames are built byte by byte, the expected
// message stream is queued as each frame is sent and popped as the DUT emits it.
module tb_tb_icmp_rx_parser;

    localparam logic [31:0] LOCAL_IP = 32'hC0A8_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic [7:0]  rx_data;
    logic        o_icmp_valid;
    logic        o_msg_valid;
    logic [7:0]  o_byte;
    logic [20:0] o_initial_sum;
    logic        o_drop;
    logic        o_abort;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_drop = 0;
    int n_abort = 0;
    int n_icmp = 0;
    int e_drop = 0;
    int e_abort = 0;
    int e_icmp = 0;
    int drop_cyc = -1;
    int t13 = 0;

    logic [8:0]  exp_q[$];   // {icmp_valid, byte}
    logic [7:0]  frm[$];
    logic [20:0] exp_sum = '0;
    logic [8:0]  mon_e;
    logic [31:0] csum_acc = '0;
    logic [7:0]  hi_byte = '0;
    logic        phase = 1'b0;

    tb_icmp_rx_parser #(
        .LOCAL_IP   (LOCAL_IP),
        .REPLY_TYPE (8'h00)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_rx_valid    (rx_valid),
        .i_rx_sof      (rx_sof),
        .i_rx_eof      (rx_eof),
        .i_rx_data     (rx_data),
        .o_icmp_valid  (o_icmp_valid),
        .o_msg_valid   (o_msg_valid),
        .o_byte        (o_byte),
        .o_initial_sum (o_initial_sum),
        .o_drop        (o_drop),
        .o_abort       (o_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cks(input logic [31:0] s);
        logic [31:0] t;
        t = {16'd0, s[15:0]} + {16'd0, s[31:16]};
        t = {16'd0, t[15:0]} + {16'd0, t[31:16]};
        return ~t[15:0];
    endfunction

    task automatic build(input logic [15:0] etype, input logic [15:0] tlen,
                         input logic [7:0] itype, input logic [7:0] code,
                         input logic [31:0] dip, input int plen,
                         input logic [7:0] pbase, input logic [7:0] pstep);
        logic [7:0] b;
        frm.delete();
        for (int i = 0; i < 12; i++) frm.push_back(8'hF0 + 8'(i));
        frm.push_back(etype[15:8]); frm.push_back(etype[7:0]);
        frm.push_back(8'h45);       frm.push_back(8'h00);
        frm.push_back(tlen[15:8]);  frm.push_back(tlen[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h01); frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(8'h01); frm.push_back(8'h00); frm.push_back(8'h00);
        frm.push_back(8'hC0); frm.push_back(8'hA8); frm.push_back(8'h00); frm.push_back(8'h64);
        frm.push_back(dip[31:24]); frm.push_back(dip[23:16]);
        frm.push_back(dip[15:8]);  frm.push_back(dip[7:0]);
        frm.push_back(itype); frm.push_back(code); frm.push_back(8'h12); frm.push_back(8'h34);
        b = pbase;
        for (int i = 0; i < plen; i++) begin
            frm.push_back(b);
            b = b + pstep;
        end
    endtask

    task automatic push_msg(input int nfwd, input logic [7:0] pbase, input logic [7:0] pstep,
                            input bit pad);
        logic [7:0] b;
        exp_q.push_back({1'b1, 8'h00});
        b = pbase;
        for (int i = 0; i < nfwd; i++) begin
            exp_q.push_back({1'b0, b});
            b = b + pstep;
        end
        if (pad) exp_q.push_back({1'b0, 8'h00});
    endtask

    // Send frm[0..last]; optional eof on last byte and one idle cycle before byte gap
    task automatic send(input int last, input bit do_eof, input int gap);
        for (int i = 0; i <= last; i++) begin
            if (i == gap) begin
                @(posedge clk); #1;
                rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'h00;
            end
            @(posedge clk); #1;
            rx_valid = 1'b1;
            rx_sof   = (i == 0);
            rx_eof   = do_eof && (i == last);
            rx_data  = frm[i];
            if (i == 13) t13 = cyc + 1;
        end
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'h00;
    endtask

    task automatic frame_done(input string tag);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_drops"}, 64'(n_drop), 64'(e_drop));
        chk({tag, "_aborts"}, 64'(n_abort), 64'(e_abort));
        chk({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Output monitor / scoreboard consumer
    initial forever begin
        @(negedge clk);
        if (o_drop) begin
            n_drop++;
            drop_cyc = cyc;
        end
        if (o_abort) n_abort++;
        if (o_msg_valid) begin
            if (exp_q.size() > 0) mon_e = exp_q.pop_front();
            else mon_e = 9'h1FF;
            chk("msg_byte", 64'({o_icmp_valid, o_byte}), 64'(mon_e));
            if (o_icmp_valid) begin
                n_icmp++;
                chk("initial_sum", 64'(o_initial_sum), 64'(exp_sum));
                csum_acc = {11'd0, o_initial_sum};
                phase = 1'b0;
            end else if (!phase) begin
                hi_byte = o_byte;
                phase = 1'b1;
            end else begin
                csum_acc = csum_acc + {16'd0, hi_byte, o_byte};
                phase = 1'b0;
            end
        end else begin
            chk("idle_outputs", 64'({o_icmp_valid, o_byte}), 64'd0);
        end
    end

    initial begin
        rst_n = 1'b0;
        rx_valid = 1'b0; rx_sof = 1'b0; rx_eof = 1'b0; rx_data = 8'h00;
        #2;
        chk("reset_state", 64'({o_icmp_valid, o_msg_valid, o_byte, o_initial_sum, o_drop, o_abort}),
            64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Echo request, 8-byte payload 01..08
        build(16'h0800, 16'd36, 8'h08, 8'h00, LOCAL_IP, 8, 8'h01, 8'h01);
        exp_sum = 21'h0;
        push_msg(8, 8'h01, 8'h01, 1'b0);
        e_icmp++;
        send(45, 1'b1, -1);
        frame_done("echo8");
        chk("echo8_csum", 64'(cks(csum_acc)), 64'h0000_EFEB);

        // ARP ethertype rejected right after byte 13
        build(16'h0806, 16'd36, 8'h08, 8'h00, LOCAL_IP, 8, 8'h01, 8'h01);
        e_drop++;
        send(45, 1'b1, -1);
        frame_done("arp");
        chk("arp_drop_timing", 64'(drop_cyc), 64'(t13));

        // Odd payload AA BB CC with pad byte
        build(16'h0800, 16'd31, 8'h08, 8'h00, LOCAL_IP, 3, 8'hAA, 8'h11);
        push_msg(3, 8'hAA, 8'h11, 1'b1);
        e_icmp++;
        send(40, 1'b1, -1);
        frame_done("odd3");
        chk("odd3_csum", 64'(cks(csum_acc)), 64'h0000_8943);

        // ICMP type 0 is not an echo request
        build(16'h0800, 16'd36, 8'h00, 8'h00, LOCAL_IP, 8, 8'h01, 8'h01);
        e_drop++;
        send(45, 1'b1, -1);
        frame_done("type0");

        // Wrong destination address
        build(16'h0800, 16'd36, 8'h08, 8'h00, 32'hC0A8_0002, 8, 8'h01, 8'h01);
        e_drop++;
        send(45, 1'b1, -1);
        frame_done("wrong_ip");

        // total_len=40 but eof after 5 payload bytes
        build(16'h0800, 16'd40, 8'h08, 8'h00, LOCAL_IP, 5, 8'h21, 8'h01);
        push_msg(5, 8'h21, 8'h01, 1'b0);
        e_icmp++;
        e_abort++;
        send(42, 1'b1, -1);
        frame_done("trunc");

        // One-cycle gap before the fourth payload byte
        build(16'h0800, 16'd36, 8'h08, 8'h00, LOCAL_IP, 8, 8'h31, 8'h01);
        push_msg(3, 8'h31, 8'h01, 1'b0);
        e_icmp++;
        e_abort++;
        send(45, 1'b1, 41);
        frame_done("gap");

        // Reset mid-payload: outputs clear at once, no abort
        build(16'h0800, 16'd36, 8'h08, 8'h05, LOCAL_IP, 8, 8'h00, 8'h01);
        exp_sum = 21'h5;
        push_msg(8, 8'h00, 8'h01, 1'b0);
        e_icmp++;
        send(40, 1'b0, -1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs",
            64'({o_icmp_valid, o_msg_valid, o_byte, o_initial_sum, o_drop, o_abort}), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        frame_done("reset");

        // Min-size frame: Ethernet padding past total_len is not forwarded
        build(16'h0800, 16'd30, 8'h08, 8'h00, LOCAL_IP, 2, 8'h11, 8'h11);
        while (frm.size() < 60) frm.push_back(8'h5A);
        exp_sum = 21'h0;
        push_msg(2, 8'h11, 8'h11, 1'b0);
        e_icmp++;
        send(59, 1'b1, -1);
        frame_done("minsize");
        chk("minsize_csum", 64'(cks(csum_acc)), 64'h0000_EEDD);

        chk("icmp_count", 64'(n_icmp), 64'(e_icmp));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
